stack16: RTL and testbench
==========================

Name: stack16

Overview:
- LIFO stack of 16-bit words for the CPU's call/return and data-stack paths.
- Pairs with Reg16: Reg16 captures a word; stack16 is the read side that hands captured words back in reverse order.
- The push side accepts D from the datapath; the pop side presents the top of stack on a registered Q.
- Includes occupancy flags and sticky error flags for the control unit.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 16, number of entries; must be a power of two, at least 2.
- CW, 5, count width; equals log2(DEPTH)+1.

Ports:
- CLK  input  1  clock; all state changes on posedge CLK.
- RES  input  1  synchronous active-high reset, sampled on posedge CLK.
- PUSH  input  1  push D this cycle.
- POP  input  1  pop the top entry this cycle.
- D  input  WIDTH  data to push.
- Q  output  WIDTH  registered top-of-stack value; 0 when empty.
- COUNT  output  CW  registered number of valid entries, 0..DEPTH.
- EMPTY  output  1  COUNT==0, registered.
- FULL  output  1  COUNT==DEPTH, registered.
- OVF  output  1  sticky overflow: a push was attempted while full.
- UNF  output  1  sticky underflow: a pop was attempted while empty.

Behaviour:
- Reset (RES=1 at posedge):
  - Q=0, COUNT=0, EMPTY=1, FULL=0, OVF=0, UNF=0.
  - Storage contents are don't-care.
  - RES overrides PUSH/POP in the same cycle.
  - Reset mid-sequence discards all entries.
- All outputs are registered. Each operation takes effect at the posedge where it is sampled; the new Q/COUNT/flags are visible immediately after that edge (1-cycle latency).
- Operation is decoded from {PUSH,POP} against the current COUNT:
  - 00: hold all state.
  - 10, not full: mem[COUNT]<=D; COUNT+1; Q<=D.
  - 10, full: no change to storage, COUNT or Q; OVF<=1.
  - 01, not empty: COUNT-1; Q<=mem[COUNT-2] if COUNT>=2, else 0.
  - 01, empty: no change; UNF<=1.
  - 11, not empty: replace top. mem[COUNT-1]<=D; COUNT unchanged; Q<=D. No flag is set, even when full.
  - 11, empty: the push takes effect as in "10, not full"; the pop is ignored; UNF<=1.
- Q is the registered top of stack. It is never driven from a combinational array read to the output.
- OVF and UNF stay set until RES. They do not block further operations.
- COUNT arithmetic is unsigned CW bits and never wraps; saturation is enforced by the full/empty guards.
- Pushing the same value back-to-back is legal, with no special handling.

Decomposition:
- Shared package (stack_pkg):
  - WIDTH and DEPTH defaults.
  - Op-code localparams OP_NONE/OP_PUSH/OP_POP/OP_REPL for the {PUSH,POP} decode.
- Storage is a natural sub-module, stack_ram:
  - DEPTH x WIDTH array, one synchronous write port, one asynchronous read port addressed by COUNT-2.
  - No reset on the array.
- stack16 holds the count, the top register, the flags and the op decode.

Test Plan:
- Reset, then push 0x1111, 0x2222, 0x3333 on consecutive cycles -> after each edge Q = 0x1111 / 0x2222 / 0x3333; COUNT = 1 / 2 / 3; EMPTY=0.
- Continue: pop three times -> Q = 0x2222, then 0x1111, then 0x0000; COUNT = 2, 1, 0; EMPTY=1 after the third pop; UNF stays 0.
- Push 16 words 0x0000..0x000F, then push 0xBEEF -> FULL=1, COUNT=16, Q=0x000F, OVF=1. Next pop -> Q=0x000E, COUNT=15, FULL=0, OVF still 1.
- With COUNT=2 (top 0x00AA, below 0x0055), assert PUSH+POP with D=0x1234 -> Q=0x1234, COUNT=2. Then pop -> Q=0x0055.
- Empty stack, assert POP -> UNF=1, COUNT=0, Q=0. Then assert PUSH+POP with D=0x7777 -> COUNT=1, Q=0x7777, UNF=1.
- With COUNT=5 and OVF=UNF=1, assert RES together with PUSH -> next cycle Q=0, COUNT=0, EMPTY=1, OVF=0, UNF=0.

Source files
------------

// File: rtl/stack16_pkg.sv
// Shared definitions for the stack16 LIFO: default geometry and the {PUSH,POP} op codes.
package stack16_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 16;
  localparam int CW_DEF    = $clog2(DEPTH_DEF) + 1;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

endpackage

// File: rtl/stack16_if.sv
// Push/pop request and status bundle between the datapath (master) and the stack (slave).
interface stack16_if
  import stack16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = CW_DEF
) ();

  logic             PUSH;
  logic             POP;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic [CW-1:0]    COUNT;
  logic             EMPTY;
  logic             FULL;
  logic             OVF;
  logic             UNF;

  modport master (
    output PUSH, POP, D,
    input  Q, COUNT, EMPTY, FULL, OVF, UNF
  );

  modport slave (
    input  PUSH, POP, D,
    output Q, COUNT, EMPTY, FULL, OVF, UNF
  );

endinterface

// File: rtl/stack16_ram.sv
// Stack storage: one synchronous write port, one asynchronous read port, no reset on the array.
module stack16_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack16.sv
// LIFO stack top: op decode, entry count, registered top-of-stack and sticky error flags.
module stack16
  import stack16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = CW_DEF
) (
  input logic      CLK,
  input logic      RES,
  stack16_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] q, q_n;
  logic             empty_r, full_r;
  logic             ovf, ovf_n, unf, unf_n;
  logic             we;
  logic [AW-1:0]    waddr, raddr;
  logic [WIDTH-1:0] rdata;
  logic [1:0]       op;

  assign op = {bus.PUSH, bus.POP};

  // The entry below the top sits at COUNT-2; only consulted when COUNT>=2.
  assign raddr = AW'(cnt - CW'(2));

  stack16_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .CLK   (CLK),
    .we    (we),
    .waddr (waddr),
    .wdata (bus.D),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    we    = 1'b0;
    waddr = cnt[AW-1:0];
    cnt_n = cnt;
    q_n   = q;
    ovf_n = ovf;
    unf_n = unf;
    case (op)
      OP_PUSH: begin
        if (!full_r) begin
          we    = 1'b1;
          cnt_n = cnt + CW'(1);
          q_n   = bus.D;
        end else begin
          ovf_n = 1'b1;
        end
      end
      OP_POP: begin
        if (!empty_r) begin
          cnt_n = cnt - CW'(1);
          q_n   = (cnt >= CW'(2)) ? rdata : '0;
        end else begin
          unf_n = 1'b1;
        end
      end
      OP_REPL: begin
        we  = 1'b1;
        q_n = bus.D;
        if (!empty_r) begin
          waddr = AW'(cnt - CW'(1));
        end else begin
          // Nothing to pop: behaves as a plain push, but the pop attempt is still an underflow.
          cnt_n = cnt + CW'(1);
          unf_n = 1'b1;
        end
      end
      default: ;
    endcase
    if (RES) we = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      cnt     <= '0;
      q       <= '0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      q       <= q_n;
      empty_r <= (cnt_n == '0);
      full_r  <= (cnt_n == CW'(DEPTH));
      ovf     <= ovf_n;
      unf     <= unf_n;
    end
  end

  assign bus.Q     = q;
  assign bus.COUNT = cnt;
  assign bus.EMPTY = empty_r;
  assign bus.FULL  = full_r;
  assign bus.OVF   = ovf;
  assign bus.UNF   = unf;

endmodule

// File: tb/tb_stack16.sv
// Self-checking bench for stack16: directed scenarios plus random ops against a queue-based model.
module tb_stack16;
  import stack16_pkg::*;

  localparam int W  = 16;
  localparam int DP = 16;
  localparam int C  = 5;

  logic CLK = 1'b0;
  logic RES = 1'b1;
  always #5 CLK = ~CLK;

  stack16_if #(.WIDTH(W), .CW(C)) bus ();

  stack16 #(.WIDTH(W), .DEPTH(DP), .CW(C)) dut (
    .CLK (CLK),
    .RES (RES),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a queue whose back is the top of stack, plus sticky flags.
  logic [W-1:0] mq[$];
  bit           movf, munf;

  function automatic logic [24:0] obs();
    return {bus.Q, bus.COUNT, bus.EMPTY, bus.FULL, bus.OVF, bus.UNF};
  endfunction

  function automatic logic [24:0] model_vec();
    logic [W-1:0] top;
    int n;
    n   = mq.size();
    top = (n > 0) ? mq[n-1] : '0;
    return {top, C'(n), n == 0, n == DP, movf, munf};
  endfunction

  // Apply one cycle of stimulus and advance the model; outputs are sampled 1 time unit after the edge.
  task automatic step(input bit pu, input bit po, input logic [W-1:0] d, input bit rs);
    @(negedge CLK);
    bus.PUSH = pu;
    bus.POP  = po;
    bus.D    = d;
    RES      = rs;
    @(posedge CLK);
    #1;
    if (rs) begin
      mq.delete();
      movf = 0;
      munf = 0;
    end else begin
      case ({pu, po})
        2'b10: if (mq.size() < DP) mq.push_back(d); else movf = 1;
        2'b01: if (mq.size() > 0) void'(mq.pop_back()); else munf = 1;
        2'b11: if (mq.size() > 0) mq[mq.size()-1] = d;
               else begin mq.push_back(d); munf = 1; end
        default: ;
      endcase
    end
    bus.PUSH = 1'b0;
    bus.POP  = 1'b0;
    RES      = 1'b0;
  endtask

  task automatic test_reset();
    step(1, 0, 16'hAAAA, 1);
    step(0, 0, 16'h0000, 1);
    n_cmp++;
    if (obs() !== {16'h0000, 5'd0, 4'b1000}) begin
      n_err++;
      $display("FAIL reset_state got %h want %h", obs(), {16'h0000, 5'd0, 4'b1000});
    end
  endtask

  task automatic test_push_pop();
    logic [W-1:0] vals [3];
    logic [W-1:0] popq [3];
    vals = '{16'h1111, 16'h2222, 16'h3333};
    popq = '{16'h2222, 16'h1111, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      step(1, 0, vals[i], 0);
      n_cmp++;
      if (obs() !== {vals[i], C'(i + 1), 4'b0000}) begin
        n_err++;
        $display("FAIL push%0d got %h want %h", i, obs(), {vals[i], C'(i + 1), 4'b0000});
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 16'hDEAD, 0);
      n_cmp++;
      if (obs() !== {popq[i], C'(2 - i), (i == 2), 3'b000}) begin
        n_err++;
        $display("FAIL pop%0d got %h want %h", i, obs(), {popq[i], C'(2 - i), (i == 2), 3'b000});
      end
    end
  endtask

  task automatic test_full();
    step(0, 0, 16'h0, 1);
    for (int i = 0; i < DP; i++) step(1, 0, W'(i), 0);
    n_cmp++;
    if (obs() !== {16'h000F, 5'd16, 4'b0100}) begin
      n_err++;
      $display("FAIL fill got %h want %h", obs(), {16'h000F, 5'd16, 4'b0100});
    end
    step(1, 0, 16'hBEEF, 0);
    n_cmp++;
    if (obs() !== {16'h000F, 5'd16, 4'b0110}) begin
      n_err++;
      $display("FAIL overflow got %h want %h", obs(), {16'h000F, 5'd16, 4'b0110});
    end
    step(0, 1, 16'h0, 0);
    n_cmp++;
    if (obs() !== {16'h000E, 5'd15, 4'b0010}) begin
      n_err++;
      $display("FAIL pop_after_ovf got %h want %h", obs(), {16'h000E, 5'd15, 4'b0010});
    end
    step(1, 0, 16'h0F0F, 0);
    step(1, 1, 16'h5A5A, 0);
    n_cmp++;
    if (obs() !== {16'h5A5A, 5'd16, 4'b0110}) begin
      n_err++;
      $display("FAIL repl_full got %h want %h", obs(), {16'h5A5A, 5'd16, 4'b0110});
    end
  endtask

  task automatic test_replace();
    step(0, 0, 16'h0, 1);
    step(1, 0, 16'h0055, 0);
    step(1, 0, 16'h00AA, 0);
    step(1, 1, 16'h1234, 0);
    n_cmp++;
    if (obs() !== {16'h1234, 5'd2, 4'b0000}) begin
      n_err++;
      $display("FAIL replace got %h want %h", obs(), {16'h1234, 5'd2, 4'b0000});
    end
    step(0, 1, 16'h0, 0);
    n_cmp++;
    if (obs() !== {16'h0055, 5'd1, 4'b0000}) begin
      n_err++;
      $display("FAIL pop_after_repl got %h want %h", obs(), {16'h0055, 5'd1, 4'b0000});
    end
  endtask

  task automatic test_underflow();
    step(0, 0, 16'h0, 1);
    step(0, 1, 16'h0, 0);
    n_cmp++;
    if (obs() !== {16'h0000, 5'd0, 4'b1001}) begin
      n_err++;
      $display("FAIL underflow got %h want %h", obs(), {16'h0000, 5'd0, 4'b1001});
    end
    step(1, 1, 16'h7777, 0);
    n_cmp++;
    if (obs() !== {16'h7777, 5'd1, 4'b0001}) begin
      n_err++;
      $display("FAIL repl_empty got %h want %h", obs(), {16'h7777, 5'd1, 4'b0001});
    end
    step(1, 0, 16'h7777, 0);
    n_cmp++;
    if (obs() !== {16'h7777, 5'd2, 4'b0001}) begin
      n_err++;
      $display("FAIL push_same got %h want %h", obs(), {16'h7777, 5'd2, 4'b0001});
    end
  endtask

  task automatic test_reset_mid();
    step(0, 0, 16'h0, 1);
    step(0, 1, 16'h0, 0);
    for (int i = 0; i < DP + 1; i++) step(1, 0, W'(16'h100 + i), 0);
    for (int i = 0; i < DP - 5; i++) step(0, 1, 16'h0, 0);
    n_cmp++;
    if (obs() !== {16'h0104, 5'd5, 4'b0011}) begin
      n_err++;
      $display("FAIL pre_reset got %h want %h", obs(), {16'h0104, 5'd5, 4'b0011});
    end
    step(1, 0, 16'h9999, 1);
    n_cmp++;
    if (obs() !== {16'h0000, 5'd0, 4'b1000}) begin
      n_err++;
      $display("FAIL reset_mid got %h want %h", obs(), {16'h0000, 5'd0, 4'b1000});
    end
  endtask

  task automatic test_random();
    int thr;
    bit pu, po, rs;
    step(0, 0, 16'h0, 1);
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) thr = $urandom_range(20, 80);
      pu = ($urandom_range(0, 99) < thr);
      po = ($urandom_range(0, 99) >= thr);
      if ($urandom_range(0, 7) == 0) begin pu = 1; po = 1; end
      rs = ($urandom_range(0, 149) == 0);
      step(pu, po, W'($urandom), rs);
      n_cmp++;
      if (obs() !== model_vec()) begin
        n_err++;
        $display("FAIL random step %0d op %b%b rst %0b got %h want %h",
                 i, pu, po, rs, obs(), model_vec());
      end
    end
  endtask

  initial begin
    bus.PUSH = 1'b0;
    bus.POP  = 1'b0;
    bus.D    = '0;
    test_reset();
    test_push_pop();
    test_full();
    test_replace();
    test_underflow();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
